mem_2r1w: RTL and testbench
===========================

# mem_2r1w

Parametrised successor to the team's 32x32 single-port memory: one write port with byte enables and two independent registered read ports, each with a valid strobe. After every reset, a built-in initialisation walker clears all entries to zero and then raises `ready`. Sits in the I-type datapath as data/register storage and serves two operand reads per cycle.

## Interface
- `DATA_W`, 32, word width in bits; must be a multiple of 8
- `ADDR_W`, 5, address width; depth is 2**ADDR_W entries
- `clk`  input  1  single clock; all logic on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `wr_en`  input  1  write request
- `wr_addr`  input  ADDR_W  write address
- `wr_data`  input  DATA_W  write data
- `wr_be`  input  DATA_W/8  byte enables; bit i covers `wr_data[8i+7:8i]`
- `rd_en_a`, `rd_en_b`  input  1  read request, ports A/B
- `rd_addr_a`, `rd_addr_b`  input  ADDR_W  read address, ports A/B
- `rd_data_a`, `rd_data_b`  output  DATA_W  registered read data
- `rd_valid_a`, `rd_valid_b`  output  1  read data valid, one-cycle pulse per accepted read
- `ready`  output  1  initialisation complete; requests are accepted only while high

## Operation
- FSM states: INIT and READY.
- Any edge with `rst`=1 sets:
  - state=INIT, `init_ptr`=0, `ready`=0.
  - `rd_data_a/b`=0, `rd_valid_a/b`=0.
- INIT, each edge with `rst`=0:
  - `mem[init_ptr]`=0, then `init_ptr`++.
  - On the edge that writes address 2**ADDR_W-1: go to READY and set `ready`=1.
- In INIT, all `wr_en`/`rd_en_*` requests are ignored. No memory change, `rd_valid_*` stay 0, and `rd_data_*` hold 0.
- READY write: when `wr_en`=1, for each i with `wr_be[i]`=1, byte i of `mem[wr_addr]` takes `wr_data` byte i. Unselected bytes are unchanged. `wr_en`=1 with `wr_be`=0 is a no-op.
- READY read, per port independently:
  - `rd_en_x`=1: capture `mem[rd_addr_x]` into `rd_data_x` and assert `rd_valid_x` for the next cycle.
  - `rd_en_x`=0: `rd_valid_x`=0 and `rd_data_x` holds its last value.
- Both ports may read the same address in the same cycle; both return identical data.
- Same-address read/write collision (read port address equals `wr_addr`, both enabled, same edge): behaviour is set by the macro under Configuration.
- `rst` asserted mid-operation, including mid-INIT: all contents are cleared again through a full INIT pass. No partial state survives.

## Timing
- Read latency is 1 cycle: request sampled at edge N; `rd_data`/`rd_valid` are valid from edge N until edge N+1.
- Write latency is 1 cycle: data written at edge N is readable by a request sampled at edge N+1, giving data after edge N+1.
- Init duration: `ready` rises at the 2**ADDR_W-th edge with `rst` low after reset. For ADDR_W=5, that is 32 cycles.
- Full throughput: one write and two reads every cycle while `ready`=1, with no stalls.
- Reset values: `ready`=0, `rd_valid_a/b`=0, `rd_data_a/b`=0.

## Configuration
- Macro: `MEM_BYPASS_EN`.
- Defined (write-first): on a collision, the read port returns the merged word. Bytes enabled by `wr_be` come from `wr_data`; the remaining bytes come from the old `mem` value.
- Undefined (read-first): on a collision, the read port returns the pre-write contents.
- In both modes the memory holds the merged word after the edge.

## Test plan
- Reset/init: hold `rst` 2 cycles, then release.
  - `ready`=0 for 31 edges and rises on the 32nd.
  - A `rd_en_a` at address 3 issued during INIT gives no `rd_valid_a`.
  - After `ready`, reads of addresses 0..31 all return 0.
- Basic write/read: write 8←6, 11←9, 15←13 (`wr_be`=4'hF), then read.
  - Port A reads 8, 10, 15, 12 → 6, 0, 13, 0, each with a `rd_valid_a` pulse 1 cycle later.
  - Port B reads the same sequence in parallel with identical results.
- Byte enables: write 20←32'hAABBCCDD with `wr_be`=4'hF, then 20←32'h11223344 with `wr_be`=4'b0101. Read 20 → 32'hAA22CC44.
- Collision: with 5 holding 32'h0, write 5←32'hDEADBEEF (`wr_be`=4'hF) while port A reads 5 on the same edge.
  - Defined: `rd_data_a`=32'hDEADBEEF.
  - Undefined: `rd_data_a`=32'h0.
  - The next read of 5 returns 32'hDEADBEEF in both modes.
- Mid-operation reset: write 7←32'h55, pulse `rst` for 1 cycle during an active read.
  - `rd_valid` drops to 0 and `ready` drops to 0.
  - After the new INIT completes, reading 7 returns 0.
- Hold behaviour: read 8 (value 6), then `rd_en_a`=0 for 3 cycles. `rd_data_a` stays 6 and `rd_valid_a`=0 throughout.

Source files
------------

// File: rtl/mem_2r1w.sv
// mem_2r1w: 2**ADDR_W x DATA_W storage with one byte-enabled write port and
// two registered read ports. After every reset an init walker clears every
// entry to zero, then raises ready.
// Optional feature: define MEM_BYPASS_EN for write-first collision behaviour
// (a read at the write address sees the merged word). Left undefined, the
// collision is read-first (the read sees the pre-write contents).
module mem_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic                rd_valid_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_valid_b,
  output logic                ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]   rd_data_b_q, rd_data_b_d;
  logic                rd_valid_a_q, rd_valid_a_d;
  logic                rd_valid_b_q, rd_valid_b_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd_word_a, rd_word_b;

  // Merge enabled write bytes over the current contents of the target word.
  always_comb begin
    wr_merged = mem_q[wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  // Read-port source word, optionally bypassing the write on an address match.
  always_comb begin
    rd_word_a = mem_q[rd_addr_a];
    rd_word_b = mem_q[rd_addr_b];
`ifdef MEM_BYPASS_EN
    if (wr_en && (rd_addr_a == wr_addr)) rd_word_a = wr_merged;
    if (wr_en && (rd_addr_b == wr_addr)) rd_word_b = wr_merged;
`else
`endif
  end

  // Next-state: init walker in INIT, write/read servicing in READY.
  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    ready_d      = ready_q;
    rd_data_a_d  = rd_data_a_q;
    rd_data_b_d  = rd_data_b_q;
    rd_valid_a_d = 1'b0;
    rd_valid_b_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_merged;
    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_ptr_q;
        mem_wdata  = '0;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      ST_READY: begin
        mem_we = wr_en && (|wr_be);
        if (rd_en_a) begin
          rd_data_a_d  = rd_word_a;
          rd_valid_a_d = 1'b1;
        end
        if (rd_en_b) begin
          rd_data_b_d  = rd_word_b;
          rd_valid_b_d = 1'b1;
        end
      end
    endcase
  end

  // Control and read-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      ready_q      <= 1'b0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      ready_q      <= ready_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
    end
  end

  // Storage array; contents are cleared by the walker, not by reset itself.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_mem_2r1w.sv
// Scoreboard bench for mem_2r1w: stimulus pushes expected read data, a
// negedge monitor pops and compares on every rd_valid pulse and also checks
// ready and hold behaviour against flags set by the stimulus.
module tb_mem_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en_a, rd_en_b;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        ready;

  mem_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .ready(ready)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  int          checks   = 0;
  int          failures = 0;

  logic        mon_en     = 1'b0;
  logic        exp_ready  = 1'b0;
  logic        chk_hold_a = 1'b0;
  logic [31:0] hold_val   = '0;
  logic        chk_no_vld = 1'b0;
  logic        chk_drain  = 1'b0;

`ifdef MEM_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] COLL_EXP = 32'h0;
`endif

  // Monitor: all comparisons happen here, away from the rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (ready !== exp_ready) begin
        failures++;
        $display("FAIL ready: got %0b expected %0b at %0t", ready, exp_ready, $time);
      end
      if (rd_valid_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid_a: data %h with empty queue at %0t", rd_data_a, $time);
        end else begin
          logic [31:0] e;
          e = exp_a.pop_front();
          if (rd_data_a !== e) begin
            failures++;
            $display("FAIL rd_data_a: got %h expected %h at %0t", rd_data_a, e, $time);
          end
        end
      end
      if (rd_valid_b) begin
        checks++;
        if (exp_b.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid_b: data %h with empty queue at %0t", rd_data_b, $time);
        end else begin
          logic [31:0] e;
          e = exp_b.pop_front();
          if (rd_data_b !== e) begin
            failures++;
            $display("FAIL rd_data_b: got %h expected %h at %0t", rd_data_b, e, $time);
          end
        end
      end
      if (chk_hold_a) begin
        checks++;
        if (rd_data_a !== hold_val || rd_valid_a !== 1'b0) begin
          failures++;
          $display("FAIL hold_a: got data %h valid %0b expected data %h valid 0 at %0t",
                   rd_data_a, rd_valid_a, hold_val, $time);
        end
      end
      if (chk_no_vld) begin
        checks++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
          failures++;
          $display("FAIL no_valid: got valid_a %0b valid_b %0b expected 0 0 at %0t",
                   rd_valid_a, rd_valid_b, $time);
        end
      end
      if (chk_drain) begin
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
          failures++;
          $display("FAIL drain: pending a=%0d b=%0d expected 0 0", exp_a.size(), exp_b.size());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    idle();
  endtask

  task automatic do_read(input logic ea, input logic [4:0] aa, input logic [31:0] xa,
                         input logic eb, input logic [4:0] ab, input logic [31:0] xb);
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    if (ea) exp_a.push_back(xa);
    if (eb) exp_b.push_back(xb);
    tick();
    idle();
  endtask

  // Reset for n cycles, then walk through INIT; ready is expected only on edge 32.
  task automatic reset_and_init(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      mon_en = 1'b1; exp_ready = 1'b0; chk_no_vld = 1'b1;
      chk_hold_a = 1'b1; hold_val = '0;
    end
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      if (e == 5) begin
        rd_en_a = 1'b1; rd_addr_a = 5'd3;
      end
      tick();
      idle();
      exp_ready = (e == 32);
    end
    chk_no_vld = 1'b0; chk_hold_a = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;

    reset_and_init(2);
    for (int i = 0; i < 32; i++) do_read(1'b1, 5'(i), 32'h0, 1'b1, 5'(31 - i), 32'h0);

    // Basic writes and parallel reads on both ports.
    do_write(5'd8,  32'd6,  4'hF);
    do_write(5'd11, 32'd9,  4'hF);
    do_write(5'd15, 32'd13, 4'hF);
    do_read(1'b1, 5'd8,  32'd6,  1'b1, 5'd8,  32'd6);
    do_read(1'b1, 5'd10, 32'd0,  1'b1, 5'd10, 32'd0);
    do_read(1'b1, 5'd15, 32'd13, 1'b1, 5'd15, 32'd13);
    do_read(1'b1, 5'd12, 32'd0,  1'b1, 5'd12, 32'd0);
    do_read(1'b1, 5'd11, 32'd9,  1'b0, 5'd0,  32'd0);

    // Hold: read 8, then three idle cycles with data held and no valid.
    do_read(1'b1, 5'd8, 32'd6, 1'b0, 5'd0, 32'd0);
    hold_val = 32'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_hold_a = 1'b1;
    end
    tick();
    chk_hold_a = 1'b0;

    // Byte enables.
    do_write(5'd20, 32'hAABBCCDD, 4'hF);
    do_write(5'd20, 32'h11223344, 4'b0101);
    do_write(5'd21, 32'h12345678, 4'b0000);
    do_read(1'b1, 5'd20, 32'hAA22CC44, 1'b1, 5'd21, 32'h0);

    // Collision on port A; port B reads a different address on the same edge.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    do_read(1'b1, 5'd5, COLL_EXP, 1'b1, 5'd8, 32'd6);
    do_read(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF);

    // Mid-operation reset during an active read.
    do_write(5'd7, 32'h55, 4'hF);
    do_read(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0);
    rd_en_a = 1'b1; rd_addr_a = 5'd7; rd_en_b = 1'b1; rd_addr_b = 5'd7;
    reset_and_init(1);
    do_read(1'b1, 5'd7, 32'h0, 1'b1, 5'd20, 32'h0);

    for (int i = 0; i < 20 && (exp_a.size() != 0 || exp_b.size() != 0); i++) tick();
    chk_drain = 1'b1;
    @(negedge clk);
    #1;
    chk_drain = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
